// File: rtl/mips_mem_pkg.sv
// -----------------------------------------------------------------------------
// Package: mips_mem_pkg
// Purpose: shared definitions for the data-memory responder slice. Holds the
//          responder FSM state encoding, the word and byte-enable widths, and
//          the helper functions that map a byte address onto a word index and
//          decide whether an address falls inside the mapped window.
// Ports:   none (package)
// -----------------------------------------------------------------------------
package mips_mem_pkg;

   localparam int WORD_W = 32;
   localparam int BE_W   = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Word offset from the window base. The caller truncates the result to its
   // own index width, which is what makes out-of-window addresses wrap.
   function automatic logic [WORD_W-1:0] word_index(input logic [WORD_W-1:0] addr,
                                                    input logic [WORD_W-1:0] base);
      return (addr - base) >> 2;
   endfunction

   // True when addr lies in [base, base + span_bytes). The span is one bit wider
   // than an address so a window reaching the top of the address space still fits.
   function automatic logic in_range(input logic [WORD_W-1:0] addr,
                                     input logic [WORD_W-1:0] base,
                                     input logic [WORD_W:0]   span_bytes);
      logic [WORD_W-1:0] offset;
      offset = addr - base;
      return (addr >= base) && ({1'b0, offset} < span_bytes);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// Module: dmem_array
// Purpose: single-port synchronous word RAM with per-byte write enables and a
//          registered read port. One access per enabled edge; the read returns
//          the contents as they were before any write on that same edge.
// Ports:
//   clk    in   1       rising-edge clock
//   en     in   1       perform an access on this edge
//   we     in   1       write the enabled bytes (read still happens)
//   be     in   BE_W    byte enables, bit i -> wdata[8i+7:8i]
//   idx    in   IDX_W   word index
//   wdata  in   WORD_W  write data
//   rdata  out  WORD_W  registered read data, held between accesses
// -----------------------------------------------------------------------------
module dmem_array
   import mips_mem_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int IDX_W = 8
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [BE_W-1:0]   be,
   input  logic [IDX_W-1:0]  idx,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH];

   // Contents are deliberately never reset; only rdata changes on an access.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < BE_W; i++) begin
               if (be[i]) begin
                  mem[idx][8*i +: 8] <= wdata[8*i +: 8];
               end
            end
         end
         rdata <= mem[idx];
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// Module: dmem_responder
// Purpose: memory-side responder for the pipeline data-memory request port.
//          Accepts one load/store at a time, waits a fixed LATENCY cycles, then
//          presents the load data or store acknowledge on a valid/ready
//          response channel until the initiator takes it.
// Build option: DMEM_RANGE_CHECK_EN -- when defined, out-of-window or
//          misaligned accesses are flagged with rsp_err, stores are dropped and
//          loads return zero. When undefined, addresses wrap modulo the depth
//          and rsp_err is tied low. The port list is the same in both builds.
// Ports:
//   clk        in   1    rising-edge clock
//   reset      in   1    synchronous, active-high
//   req_valid  in   1    request present
//   req_ready  out  1    request can be accepted this cycle
//   req_we     in   1    1 = store, 0 = load
//   req_addr   in   32   byte address (bits [1:0] ignored for indexing)
//   req_wdata  in   32   store data
//   req_be     in   4    store byte enables
//   rsp_valid  out  1    response available
//   rsp_ready  in   1    response consumed
//   rsp_rdata  out  32   load data, 0 for stores
//   rsp_err    out  1    access error flag
// -----------------------------------------------------------------------------
module dmem_responder
   import mips_mem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 256,
   parameter int          LATENCY     = 2,
   parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [WORD_W-1:0] req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   input  logic [BE_W-1:0]   req_be,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [WORD_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int         IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

   state_t            state;
   state_t            state_next;
   logic [3:0]        cnt;
   logic [3:0]        cnt_next;
   logic              accept;
   logic              commit;

   logic              we_q;
   logic [WORD_W-1:0] addr_q;
   logic [WORD_W-1:0] wdata_q;
   logic [BE_W-1:0]   be_q;

   logic              acc_we;
   logic [WORD_W-1:0] acc_addr;
   logic [WORD_W-1:0] acc_wdata;
   logic [BE_W-1:0]   acc_be;
   logic [IDX_W-1:0]  acc_idx;
   logic              acc_err;
   logic              resp_err;

   logic              ram_en;
   logic              ram_we;
   logic [WORD_W-1:0] ram_rdata;

   // State, latency counter and request latch. The latch captures the request
   // on the accepting edge so the initiator may change its inputs afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
         end
      end
   end

   // Next-state logic. commit marks the cycle whose closing edge enters RESP;
   // that edge performs the array access. With LATENCY==1 this is the accepting
   // cycle itself, so no WAIT state is visited.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      req_ready  = 1'b0;
      accept     = 1'b0;
      commit     = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept   = 1'b1;
               cnt_next = LAT_LOAD;
               if (LATENCY == 1) begin
                  state_next = RESP;
                  commit     = 1'b1;
               end else begin
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_next = (cnt != 4'd0) ? cnt - 4'd1 : 4'd0;
            if (cnt <= 4'd1) begin
               state_next = RESP;
               commit     = 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // In the LATENCY==1 case the commit happens before the latch is loaded, so
   // the array is fed straight from the request port while in IDLE.
   assign acc_we    = (state == IDLE) ? req_we    : we_q;
   assign acc_addr  = (state == IDLE) ? req_addr  : addr_q;
   assign acc_wdata = (state == IDLE) ? req_wdata : wdata_q;
   assign acc_be    = (state == IDLE) ? req_be    : be_q;
   assign acc_idx   = IDX_W'(word_index(acc_addr, ADDR_BASE));

`ifdef DMEM_RANGE_CHECK_EN
   localparam logic [WORD_W:0] SPAN_BYTES = (WORD_W+1)'(4 * DEPTH_WORDS);

   logic err_q;

   assign acc_err = !in_range(acc_addr, ADDR_BASE, SPAN_BYTES) || (acc_addr[1:0] != 2'b00);

   // Error status is captured together with the array access and held for the
   // whole response.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if (commit) begin
         err_q <= acc_err;
      end
   end

   assign resp_err = err_q;
`else
   assign acc_err  = 1'b0;
   assign resp_err = 1'b0;
`endif

   // Reset on the commit edge abandons the transaction, so it also blocks the write.
   assign ram_en = commit && !reset;
   assign ram_we = acc_we && !acc_err;

   dmem_array #(
      .DEPTH (DEPTH_WORDS),
      .IDX_W (IDX_W)
   ) u_array (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .be    (acc_be),
      .idx   (acc_idx),
      .wdata (acc_wdata),
      .rdata (ram_rdata)
   );

   assign rsp_valid = (state == RESP);
   assign rsp_err   = rsp_valid && resp_err;
   assign rsp_rdata = (rsp_valid && !we_q && !resp_err) ? ram_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// Testbench: tb_dmem_responder
// Purpose: directed self-checking bench for dmem_responder with hand-computed
//          expected values. Inputs are driven and outputs sampled on the
//          falling clock edge, away from the active rising edge. Honours
//          DMEM_RANGE_CHECK_EN for the range-check scenario.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

   localparam int          LATENCY     = 2;
   localparam int          DEPTH_WORDS = 256;
   localparam logic [31:0] ADDR_BASE   = 32'h0000_0000;
   localparam int          BUDGET      = 50;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int compareCount  = 0;
   int mismatchCount = 0;
   int cycleCount    = 0;

   dmem_responder #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .LATENCY     (LATENCY),
      .ADDR_BASE   (ADDR_BASE)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   // Free-running clock and a cycle counter used to timestamp acceptances.
   always #5 clk = ~clk;

   always @(posedge clk) cycleCount <= cycleCount + 1;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Runs one complete transaction: waits for acceptance, measures the latency
   // to rsp_valid, checks the response, optionally stalls the response for
   // holdCycles while checking it stays stable, then completes the handshake.
   task automatic applyStimulus(input string tag, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                input int holdCycles, input logic [31:0] expRdata,
                                input logic expErr);
      int waited;
      int latency;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_be    = be;
      waited    = 0;
      while (!req_ready && waited < BUDGET) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) begin
         checkOutput({tag, "_accept_timeout"}, 32'd0, 32'd1);
         req_valid = 1'b0;
         return;
      end
      @(negedge clk);
      req_valid = 1'b0;
      req_wdata = 32'h0BAD_0BAD;
      latency   = 1;
      while (!rsp_valid && latency < BUDGET) begin
         @(negedge clk);
         latency++;
      end
      if (!rsp_valid) begin
         checkOutput({tag, "_rsp_timeout"}, 32'd0, 32'd1);
         return;
      end
      checkOutput({tag, "_latency"}, 32'(latency), 32'(LATENCY));
      checkOutput({tag, "_rdata"}, rsp_rdata, expRdata);
      checkOutput({tag, "_err"}, 32'(rsp_err), 32'(expErr));
      for (int i = 0; i < holdCycles; i++) begin
         @(negedge clk);
         checkOutput({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
         checkOutput({tag, "_hold_rdata"}, rsp_rdata, expRdata);
         checkOutput({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checkOutput({tag, "_post_req_ready"}, 32'(req_ready), 32'd1);
      checkOutput({tag, "_post_rsp_valid"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin : main
      int accepts[$];
      int waited;

      reset     = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_be    = '0;
      rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Reset state, observed in the first cycle after reset.
      checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
      checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
      checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);

      $display("[TB] scenario 1: store then load word 0");
      applyStimulus("t1_store", 1'b1, 32'h0, 32'hDEAD_BEEF, 4'b1111, 0, 32'h0, 1'b0);
      applyStimulus("t1_load", 1'b0, 32'h0, 32'h0, 4'b0000, 0, 32'hDEAD_BEEF, 1'b0);

      $display("[TB] scenario 2: partial byte-enable store");
      applyStimulus("t2_store_full", 1'b1, 32'h4, 32'h1122_3344, 4'b1111, 0, 32'h0, 1'b0);
      applyStimulus("t2_store_part", 1'b1, 32'h4, 32'hAABB_CCDD, 4'b0101, 0, 32'h0, 1'b0);
      applyStimulus("t2_load", 1'b0, 32'h4, 32'h0, 4'b0000, 0, 32'h11BB_33DD, 1'b0);
      applyStimulus("t2_store_be0", 1'b1, 32'h4, 32'hFFFF_FFFF, 4'b0000, 0, 32'h0, 1'b0);

      $display("[TB] scenario 3: response stalled for 5 cycles");
      applyStimulus("t3_load_hold", 1'b0, 32'h4, 32'h0, 4'b0000, 5, 32'h11BB_33DD, 1'b0);

      $display("[TB] scenario 4: back-to-back loads");
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 32'h0;
      req_be    = 4'b0000;
      rsp_ready = 1'b1;
      for (int i = 0; i < 4 * (LATENCY + 1) + 6; i++) begin
         if (req_valid && req_ready) accepts.push_back(cycleCount);
         if (rsp_valid) checkOutput("t4_rdata", rsp_rdata, 32'hDEAD_BEEF);
         @(negedge clk);
      end
      waited = 0;
      while (req_ready && waited < BUDGET) begin
         @(negedge clk);
         waited++;
      end
      req_valid = 1'b0;
      waited    = 0;
      while (!req_ready && waited < BUDGET) begin
         @(negedge clk);
         waited++;
      end
      rsp_ready = 1'b0;
      checkOutput("t4_drained", 32'(req_ready), 32'd1);
      checkOutput("t4_accept_count_ge4", 32'(accepts.size() >= 4), 32'd1);
      if (accepts.size() >= 4) begin
         for (int i = 1; i < 4; i++) begin
            checkOutput("t4_gap", 32'(accepts[i] - accepts[i-1]), 32'(LATENCY + 1));
         end
      end

      $display("[TB] scenario 5: reset during WAIT of a store");
      applyStimulus("t5_clear", 1'b1, 32'h8, 32'h0, 4'b1111, 0, 32'h0, 1'b0);
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h8;
      req_wdata = 32'hCAFE_F00D;
      req_be    = 4'b1111;
      checkOutput("t5_ready_idle", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      checkOutput("t5_in_wait_ready", 32'(req_ready), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("t5_after_reset_ready", 32'(req_ready), 32'd1);
      for (int i = 0; i < LATENCY + 2; i++) begin
         checkOutput("t5_no_response", 32'(rsp_valid), 32'd0);
         @(negedge clk);
      end
      applyStimulus("t5_load", 1'b0, 32'h8, 32'h0, 4'b0000, 0, 32'h0, 1'b0);

      $display("[TB] scenario 6: out-of-window and misaligned accesses");
      applyStimulus("t6_store0", 1'b1, 32'h0, 32'h1234_5678, 4'b1111, 0, 32'h0, 1'b0);
`ifdef DMEM_RANGE_CHECK_EN
      applyStimulus("t6_load_mis", 1'b0, 32'h3, 32'h0, 4'b0000, 0, 32'h0, 1'b1);
      applyStimulus("t6_store_oor", 1'b1, ADDR_BASE + 32'(4 * DEPTH_WORDS), 32'h5566_7788,
                    4'b1111, 0, 32'h0, 1'b1);
      applyStimulus("t6_load0", 1'b0, 32'h0, 32'h0, 4'b0000, 0, 32'h1234_5678, 1'b0);
`else
      applyStimulus("t6_load_mis", 1'b0, 32'h3, 32'h0, 4'b0000, 0, 32'h1234_5678, 1'b0);
      applyStimulus("t6_store_wrap", 1'b1, ADDR_BASE + 32'(4 * DEPTH_WORDS), 32'h5566_7788,
                    4'b1111, 0, 32'h0, 1'b0);
      applyStimulus("t6_load0", 1'b0, 32'h0, 32'h0, 4'b0000, 0, 32'h5566_7788, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
